// File: rtl/obi_arb_pkg.sv
// Arbitration policy and index helpers for the N-to-1 OBI arbiter.
package obi_arb_pkg;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_e;

  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/obi_pkg.sv
// OBI bus request/response types shared by masters, slaves and interconnect.
package obi_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/obi_rsp_id_fifo.sv
// In-order queue of granted master indices awaiting their response.
module obi_rsp_id_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (do_pop)
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/obi_arb_n_to_one.sv
// N-to-1 OBI arbiter: combinational grant path, address-phase lock and
// in-order response routing through a bounded ID FIFO.
module obi_arb_n_to_one
  import obi_pkg::*;
  import obi_arb_pkg::*;
#(
  parameter int        NMASTER         = 4,
  parameter int        MAX_OUTSTANDING = 2,
  parameter arb_mode_e ARB_MODE        = ARB_RR,
  parameter int        IDX_W           = $clog2(NMASTER),
  localparam int       OUT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  obi_req_t  [NMASTER-1:0]   master_req_i,
  output obi_resp_t [NMASTER-1:0]   master_resp_o,
  output obi_req_t                  slave_req_o,
  input  obi_resp_t                 slave_resp_i,
  output logic      [OUT_W-1:0]     outstanding_o,
  output logic                      err_o
);

  logic [NMASTER-1:0] eligible;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d, lock_idx_q, lock_idx_d;
  logic [IDX_W-1:0]   win_idx, base, head_idx;
  logic               lock_vld_q, lock_vld_d, err_q, err_d;
  logic               win_vld, hs, rsp_pop, fifo_empty, fifo_full;
  int                 cand;

  // Full tracker blocks new address phases using the registered count only.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NMASTER; i++)
      eligible[i] = master_req_i[i].req & ~fifo_full;
  end

  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = 0;
    base    = (ARB_MODE == ARB_RR) ? rr_ptr_q : '0;
    if (lock_vld_q) begin
      win_vld = eligible[lock_idx_q];
      win_idx = lock_idx_q;
    end else begin
      // Walk downward so the candidate closest to base is taken last.
      for (int k = NMASTER - 1; k >= 0; k--) begin
        cand = (int'(base) + k) % NMASTER;
        if (eligible[IDX_W'(cand)]) begin
          win_vld = 1'b1;
          win_idx = IDX_W'(cand);
        end
      end
    end
  end

  assign hs          = win_vld & slave_resp_i.gnt;
  assign rsp_pop     = slave_resp_i.rvalid & ~fifo_empty;
  assign slave_req_o = win_vld ? master_req_i[win_idx] : '0;

  always_comb begin
    for (int i = 0; i < NMASTER; i++) begin
      master_resp_o[i].rdata  = slave_resp_i.rdata;
      master_resp_o[i].gnt    = win_vld & (win_idx == IDX_W'(i)) & slave_resp_i.gnt;
      master_resp_o[i].rvalid = rsp_pop & (head_idx == IDX_W'(i));
    end
  end

  always_comb begin
    lock_vld_d = win_vld & ~slave_resp_i.gnt;
    lock_idx_d = lock_vld_d ? win_idx : lock_idx_q;
    rr_ptr_d   = rr_ptr_q;
    if (ARB_MODE == ARB_RR && hs)
      rr_ptr_d = IDX_W'(wrap_inc(int'(win_idx), NMASTER));
    err_d = err_q | (slave_resp_i.rvalid & fifo_empty);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_ptr_q   <= '0;
      lock_vld_q <= 1'b0;
      lock_idx_q <= '0;
      err_q      <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      lock_vld_q <= lock_vld_d;
      lock_idx_q <= lock_idx_d;
      err_q      <= err_d;
    end
  end

  assign err_o = err_q;

  obi_rsp_id_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (hs),
    .pop_i   (rsp_pop),
    .data_i  (win_idx),
    .data_o  (head_idx),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (outstanding_o)
  );

endmodule
